mem_port_arb: RTL
=================

# mem_port_arb

Single-clock memory-port arbiter in the `mem_clk` domain. It accepts single-word write transactions from the FTDI receive path (`mem_idle`/`mem_wr_req`/`mem_ack`/`mem_data_next` handshake) and single-word read requests from the display refresh path. It serialises both onto one Avalon-MM-style master port toward the SDRAM controller. Reads have priority, bounded by an anti-starvation counter.

## Interface
- `RD_RUN_MAX`, default 8: max consecutive read grants while a write is pending.
- `AW`, default 25: byte-address width of both client ports.
- `mem_clk` in 1: sole clock.
- `reset` in 1: asynchronous, active-high reset.
- `mem_idle` out 1: write client may issue `mem_wr_req`.
- `mem_wr_req` in 1: write request, sampled only while `mem_idle`=1.
- `mem_wr_addr` in AW: byte address, sampled with `mem_wr_req`.
- `mem_ack` out 1: one-cycle pulse, write accepted.
- `mem_data_next` out 1: one-cycle pulse, `mem_wr_data` consumed this cycle.
- `mem_wr_data` in 32: write data; show-ahead, valid when `mem_data_next`=1.
- `vid_rd_req` in 1: read request, level; held until `vid_rd_ack`.
- `vid_rd_addr` in AW: read byte address, stable while `vid_rd_req`=1.
- `vid_rd_ack` out 1: one-cycle pulse, read accepted.
- `vid_rd_valid` out 1: one-cycle pulse, `vid_rd_data` valid.
- `vid_rd_data` out 32: read data, registered.
- `av_address` out AW-2: word address, byte address bits [AW-1:2].
- `av_write` out 1: write strobe.
- `av_read` out 1: read strobe.
- `av_writedata` out 32: write data.
- `av_byteenable` out 4: constant 4'hF.
- `av_waitrequest` in 1: slave stall.
- `av_readdata` in 32: valid in the cycle `av_read`=1 and `av_waitrequest`=0 (zero-latency slave).

## Operation
- FSM states: IDLE, WR_ACK, WR_DATA, WR_BUS, RD_BUS.
- IDLE:
  - `mem_idle`=1. This is the only state in which requests are sampled.
  - Read wins if `vid_rd_req`=1 and (`mem_wr_req`=0 or `rd_run`<RD_RUN_MAX). The winning read goes to RD_BUS, asserts `vid_rd_ack`, latches `vid_rd_addr`, and increments `rd_run`, saturating at RD_RUN_MAX.
  - Otherwise, if `mem_wr_req`=1: latch `mem_wr_addr` and go to WR_ACK.
  - Any write grant clears `rd_run`. `rd_run` also clears in IDLE when `mem_wr_req`=0.
- WR_ACK: `mem_ack`=1 for one cycle, then WR_DATA.
- WR_DATA: `mem_data_next`=1 for one cycle; latch `mem_wr_data`, then WR_BUS.
- WR_BUS: `av_write`=1 with latched address and data, held until `av_waitrequest`=0. Completes that cycle, then IDLE.
- RD_BUS: `av_read`=1 held until `av_waitrequest`=0. That cycle, register `av_readdata` into `vid_rd_data`; `vid_rd_valid` pulses the next cycle. Then IDLE.
- `mem_wr_req` asserted outside IDLE is ignored. The client de-asserts it because `mem_idle`=0.
- Word address is the byte address >> 2. Byte address bits [1:0] are ignored. No address arithmetic inside the block.
- Reset mid-transaction:
  - Every state returns to IDLE at once; all strobes drop, and the in-flight transaction is lost.
  - Reset values: `mem_idle`=1, `mem_ack`=0, `mem_data_next`=0, `vid_rd_ack`=0, `vid_rd_valid`=0, `vid_rd_data`=0, `av_write`=0, `av_read`=0, `av_address`=0, `av_writedata`=0, `rd_run`=0.

## Timing
- All outputs are registered or decoded from registered state only; there is no input-to-output combinational path.
- Write, zero wait: req sampled at cycle 0 → `mem_ack` cycle 1 → `mem_data_next` cycle 2 → `av_write` cycle 3 → `mem_idle` cycle 4. Each wait cycle adds one.
- Read, zero wait: accepted at cycle 0 with `vid_rd_ack` registered in cycle 1 → `av_read` cycle 1 → `vid_rd_valid` cycle 2 → `mem_idle` cycle 2.
- Back-to-back reads: one every 2 cycles.
- Simultaneous write and read request in IDLE: the read wins unless `rd_run`=RD_RUN_MAX.

## Structure
- Shared package `mem_port_pkg`: FSM state enum, `AV_BE_ALL`=4'hF, default `RD_RUN_MAX`.
- No sub-modules; the `rd_run` counter and FSM live in the top module.

## Test plan
- Single write to 0x000_0104, data 0xDEADBEEF, no wait → `mem_ack`@+1, `mem_data_next`@+2, `av_write`@+3 with `av_address`=0x41 and data 0xDEADBEEF, `mem_idle`=1 @+4.
- Single read of 0x000_0010; slave returns 0x12345678 with 2 wait cycles → `av_read` for 3 cycles, `vid_rd_valid` with 0x12345678 one cycle after `av_waitrequest` falls.
- `vid_rd_req` held high and `mem_wr_req` asserted together, RD_RUN_MAX=8 → exactly 8 reads, then 1 write granted, then reads resume.
- Write client emulating a 3-word block at consecutive addresses → three `av_write`s at word addresses N, N+1, N+2; `mem_ack` count = `mem_data_next` count = 3.
- `av_waitrequest` stuck high for 20 cycles during a write → `av_write` held stable for 20 cycles, `mem_idle`=0 throughout, no extra `mem_ack`.
- `reset` pulsed while in WR_BUS → `av_write`=0 the same cycle, state IDLE, `mem_idle`=1; a next request completes normally.

Source files
------------

// File: rtl/mem_port_pkg.sv
// Shared types and constants for the memory-port arbiter.
//   state_t             : arbiter FSM state encoding
//   AV_BE_ALL           : full-word byte enable driven on the Avalon port
//   RD_RUN_MAX_DEFAULT  : default limit on consecutive reads while a write waits
//   DATA_W              : client and Avalon data width
package mem_port_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_ACK  = 3'd1,
    ST_WR_DATA = 3'd2,
    ST_WR_BUS  = 3'd3,
    ST_RD_BUS  = 3'd4
  } state_t;

  localparam logic [3:0]  AV_BE_ALL          = 4'hF;
  localparam int unsigned RD_RUN_MAX_DEFAULT = 8;
  localparam int unsigned DATA_W             = 32;

endpackage

// File: rtl/mem_port_arb_if.sv
// Bundle of the three buses around the memory-port arbiter.
//   write client : mem_idle, mem_wr_req, mem_wr_addr, mem_ack, mem_data_next, mem_wr_data
//   read client  : vid_rd_req, vid_rd_addr, vid_rd_ack, vid_rd_valid, vid_rd_data
//   Avalon master: av_address, av_write, av_read, av_writedata, av_byteenable,
//                  av_waitrequest, av_readdata
// master modport is the arbiter's view; slave modport is the environment's view.
interface mem_port_arb_if #(
  parameter int unsigned AW = 25
) ();
  import mem_port_pkg::*;

  // write client
  logic              mem_idle;
  logic              mem_wr_req;
  logic [AW-1:0]     mem_wr_addr;
  logic              mem_ack;
  logic              mem_data_next;
  logic [DATA_W-1:0] mem_wr_data;

  // read client
  logic              vid_rd_req;
  logic [AW-1:0]     vid_rd_addr;
  logic              vid_rd_ack;
  logic              vid_rd_valid;
  logic [DATA_W-1:0] vid_rd_data;

  // Avalon-MM master toward the SDRAM controller
  logic [AW-3:0]     av_address;
  logic              av_write;
  logic              av_read;
  logic [DATA_W-1:0] av_writedata;
  logic [3:0]        av_byteenable;
  logic              av_waitrequest;
  logic [DATA_W-1:0] av_readdata;

  modport master (
    output mem_idle, mem_ack, mem_data_next,
    output vid_rd_ack, vid_rd_valid, vid_rd_data,
    output av_address, av_write, av_read, av_writedata, av_byteenable,
    input  mem_wr_req, mem_wr_addr, mem_wr_data,
    input  vid_rd_req, vid_rd_addr,
    input  av_waitrequest, av_readdata
  );

  modport slave (
    input  mem_idle, mem_ack, mem_data_next,
    input  vid_rd_ack, vid_rd_valid, vid_rd_data,
    input  av_address, av_write, av_read, av_writedata, av_byteenable,
    output mem_wr_req, mem_wr_addr, mem_wr_data,
    output vid_rd_req, vid_rd_addr,
    output av_waitrequest, av_readdata
  );

endinterface

// File: rtl/mem_port_arb.sv
// Memory-port arbiter: serialises single-word writes from the FTDI receive
// path and single-word reads from the display refresh path onto one
// Avalon-MM master port. Reads win, but after RD_RUN_MAX consecutive read
// grants with a write waiting, the write is granted.
//   mem_clk : sole clock
//   reset   : asynchronous, active-high
//   bus     : mem_port_arb_if.master (write client, read client, Avalon master)
module mem_port_arb
  import mem_port_pkg::*;
#(
  parameter int unsigned RD_RUN_MAX = RD_RUN_MAX_DEFAULT,
  parameter int unsigned AW         = 25
) (
  input  logic          mem_clk,
  input  logic          reset,
  mem_port_arb_if.master bus
);

  localparam int unsigned RUN_W = $clog2(RD_RUN_MAX + 1);
  localparam int unsigned WA_W  = AW - 2;

  state_t            state;
  state_t            next_state;
  logic [RUN_W-1:0]  rd_run;

  logic rd_win_c;
  logic rd_grant_c;
  logic wr_grant_c;
  logic bus_done_c;

  // Next-state and grant decode
  always_comb begin
    next_state = state;
    rd_grant_c = 1'b0;
    wr_grant_c = 1'b0;
    bus_done_c = 1'b0;
    rd_win_c   = bus.vid_rd_req &&
                 (!bus.mem_wr_req || (rd_run < RUN_W'(RD_RUN_MAX)));
    case (state)
      ST_IDLE: begin
        if (rd_win_c) begin
          rd_grant_c = 1'b1;
          next_state = ST_RD_BUS;
        end else if (bus.mem_wr_req) begin
          wr_grant_c = 1'b1;
          next_state = ST_WR_ACK;
        end
      end
      ST_WR_ACK:  next_state = ST_WR_DATA;
      ST_WR_DATA: next_state = ST_WR_BUS;
      ST_WR_BUS: begin
        if (!bus.av_waitrequest) begin
          bus_done_c = 1'b1;
          next_state = ST_IDLE;
        end
      end
      ST_RD_BUS: begin
        if (!bus.av_waitrequest) begin
          bus_done_c = 1'b1;
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge mem_clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Strobes registered from the next state so they line up with the state
  always_ff @(posedge mem_clk or posedge reset) begin
    if (reset) begin
      bus.mem_idle      <= 1'b1;
      bus.mem_ack       <= 1'b0;
      bus.mem_data_next <= 1'b0;
      bus.av_write      <= 1'b0;
      bus.av_read       <= 1'b0;
      bus.vid_rd_ack    <= 1'b0;
      bus.vid_rd_valid  <= 1'b0;
    end else begin
      bus.mem_idle      <= (next_state == ST_IDLE);
      bus.mem_ack       <= (next_state == ST_WR_ACK);
      bus.mem_data_next <= (next_state == ST_WR_DATA);
      bus.av_write      <= (next_state == ST_WR_BUS);
      bus.av_read       <= (next_state == ST_RD_BUS);
      bus.vid_rd_ack    <= rd_grant_c;
      bus.vid_rd_valid  <= (state == ST_RD_BUS) && bus_done_c;
    end
  end

  // Address/data latches; only the word part of the byte address is kept
  always_ff @(posedge mem_clk or posedge reset) begin
    if (reset) begin
      bus.av_address   <= '0;
      bus.av_writedata <= '0;
      bus.vid_rd_data  <= '0;
    end else begin
      if (rd_grant_c)
        bus.av_address <= WA_W'(bus.vid_rd_addr[AW-1:2]);
      else if (wr_grant_c)
        bus.av_address <= WA_W'(bus.mem_wr_addr[AW-1:2]);
      if (state == ST_WR_DATA)
        bus.av_writedata <= bus.mem_wr_data;
      if ((state == ST_RD_BUS) && bus_done_c)
        bus.vid_rd_data <= bus.av_readdata;
    end
  end

  // Consecutive-read counter; only counts while a write is waiting
  always_ff @(posedge mem_clk or posedge reset) begin
    if (reset) begin
      rd_run <= '0;
    end else if (state == ST_IDLE) begin
      if (!bus.mem_wr_req || wr_grant_c)
        rd_run <= '0;
      else if (rd_grant_c && (rd_run < RUN_W'(RD_RUN_MAX)))
        rd_run <= rd_run + RUN_W'(1);
    end
  end

  assign bus.av_byteenable = AV_BE_ALL;

endmodule
